// File: rtl/power_datapath.sv
// Iterative power datapath: result = x_in^k, driven by init/inc/ld_reg strobes from the controller.
// Optional OVF_SAT_EN: saturate acc/result on overflow instead of wrapping.
module power_datapath #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 16,
   parameter int N         = 2,
   parameter int CNT_W     = $clog2(N + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 init,
   input  logic                 inc,
   input  logic                 ld_reg,
   input  logic [WIDTH-1:0]     x_in,
   output logic [ACC_WIDTH-1:0] result,
   output logic [CNT_W-1:0]     power,
   output logic                 ovf,
   output logic                 seq_err,
   output logic                 res_upd
);

   localparam int PW = WIDTH + ACC_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_PEND
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_x;
   logic [ACC_WIDTH-1:0] r_acc;
   logic [ACC_WIDTH-1:0] r_result;
   logic [CNT_W-1:0]     r_power;
   logic                 r_ovf;
   logic                 r_err;
   logic                 r_upd;

   logic                 w_do_mul;
   logic                 w_publish;
   logic                 w_err_set;
   logic                 w_k_inc;
   logic [PW-1:0]        w_prod;
   logic                 w_prod_ovf;
   logic [ACC_WIDTH-1:0] w_mul_val;
   logic [ACC_WIDTH-1:0] w_acc_nxt;

   // Strobe decode; init outranks everything, ld_reg outranks inc.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_state_nxt = r_state;
      w_do_mul    = 1'b0;
      w_publish   = 1'b0;
      w_err_set   = 1'b0;
      w_k_inc     = 1'b0;
      if (init) begin
         w_state_nxt = S_ARMED;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (inc || ld_reg) w_err_set = 1'b1;
            end
            S_ARMED: begin
               if (ld_reg) begin
                  w_publish = 1'b1;
                  if (inc) w_err_set = 1'b1;
               end else if (inc) begin
                  if (r_power < CNT_W'(N)) begin
                     w_k_inc     = 1'b1;
                     w_state_nxt = S_PEND;
                  end else begin
                     w_err_set = 1'b1;
                  end
               end
            end
            S_PEND: begin
               if (ld_reg) begin
                  w_do_mul    = 1'b1;
                  w_publish   = 1'b1;
                  w_state_nxt = S_ARMED;
                  if (inc) w_err_set = 1'b1;
               end else if (inc) begin
                  w_err_set = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign w_prod     = PW'(r_acc) * PW'(r_x);
   assign w_prod_ovf = |w_prod[PW-1:ACC_WIDTH];

`ifdef OVF_SAT_EN
   // Once saturated, the accumulator stays pinned at all-ones until the next init.
   assign w_mul_val = (w_prod_ovf || r_ovf) ? {ACC_WIDTH{1'b1}} : w_prod[ACC_WIDTH-1:0];
`else
   assign w_mul_val = w_prod[ACC_WIDTH-1:0];
`endif

   assign w_acc_nxt = w_do_mul ? w_mul_val : r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_x      <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_power  <= '0;
         r_ovf    <= 1'b0;
         r_err    <= 1'b0;
         r_upd    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state <= w_state_nxt;
         if (init) begin
            r_x      <= x_in;
            r_acc    <= {{(ACC_WIDTH-1){1'b0}}, 1'b1};
            r_result <= {{(ACC_WIDTH-1){1'b0}}, 1'b1};
            r_power  <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_upd    <= 1'b1;
         end else begin
            r_acc <= w_acc_nxt;
            r_upd <= w_publish;
            if (w_publish) r_result <= w_acc_nxt;
            if (w_k_inc) r_power <= r_power + CNT_W'(1);
            if (w_do_mul && w_prod_ovf) r_ovf <= 1'b1;
            if (w_err_set) r_err <= 1'b1;
         end
      end
   end

   assign result  = r_result;
   assign power   = r_power;
   assign ovf     = r_ovf;
   assign seq_err = r_err;
   assign res_upd = r_upd;

endmodule

// File: tb/tb_power_datapath.sv
// Bench for power_datapath: N=2 and N=3 instances share stimulus; a reference model feeds a
// scoreboard of expected published results, popped whenever the selected instance pulses res_upd.
module tb_power_datapath;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init = 1'b0;
   logic        inc = 1'b0;
   logic        ld_reg = 1'b0;
   logic [7:0]  x_in = '0;

   logic [15:0] res2, res3;
   logic [1:0]  pw2, pw3;
   logic        ovf2, ovf3, err2, err3, upd2, upd3;
   logic        use3 = 1'b0;

   always #5 clk = ~clk;

   power_datapath #(.WIDTH(8), .ACC_WIDTH(16), .N(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .init(init), .inc(inc), .ld_reg(ld_reg), .x_in(x_in),
      .result(res2), .power(pw2), .ovf(ovf2), .seq_err(err2), .res_upd(upd2)
   );

   power_datapath #(.WIDTH(8), .ACC_WIDTH(16), .N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .init(init), .inc(inc), .ld_reg(ld_reg), .x_in(x_in),
      .result(res3), .power(pw3), .ovf(ovf3), .seq_err(err3), .res_upd(upd3)
   );

   wire [15:0] s_res = use3 ? res3 : res2;
   wire [1:0]  s_pw  = use3 ? pw3  : pw2;
   wire        s_ovf = use3 ? ovf3 : ovf2;
   wire        s_err = use3 ? err3 : err2;
   wire        s_upd = use3 ? upd3 : upd2;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] sb[$];
   logic [15:0] mon_exp;

   // Reference model state: 0 idle, 1 armed, 2 pending multiply
   int          m_st = 0;
   int          m_k = 0;
   logic [15:0] m_acc = '0;
   logic [7:0]  m_x = '0;
   bit          m_ovf = 1'b0;

   // Scoreboard consumer: every res_upd pulse must match the oldest expected publish.
   always @(posedge clk) begin
      #1;
      if (rst_n && s_upd) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_upd: got res_upd=1 result=%0d, required no update", s_res);
         end else begin
            mon_exp = sb.pop_front();
            if (s_res !== mon_exp) begin
               bad++;
               $display("FAIL sb_result: got %0d, required %0d", s_res, mon_exp);
            end
         end
      end
   end

   task automatic step(input bit i_init, input bit i_inc, input bit i_ld, input logic [7:0] x);
      int          n;
      logic [23:0] prod;
      n = use3 ? 3 : 2;
      @(negedge clk);
      init = i_init; inc = i_inc; ld_reg = i_ld; x_in = x;
      if (i_init) begin
         m_x = x; m_acc = 16'd1; m_k = 0; m_ovf = 1'b0; m_st = 1;
         sb.push_back(16'd1);
      end else if (i_ld) begin
         if (m_st != 0) begin
            if (m_st == 2) begin
               prod = 24'(m_acc) * 24'(m_x);
               if (prod[23:16] != 8'd0) m_ovf = 1'b1;
               m_acc = prod[15:0];
`ifdef OVF_SAT_EN
               if (m_ovf) m_acc = 16'hFFFF;
`endif
               m_st = 1;
            end
            sb.push_back(m_acc);
         end
      end else if (i_inc) begin
         if (m_st == 1 && m_k < n) begin
            m_k++; m_st = 2;
         end
      end
      @(posedge clk);
      #2;
      init = 1'b0; inc = 1'b0; ld_reg = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      total++; if (res2 !== 16'd0) begin bad++; $display("FAIL rst_result: got %0d, required 0", res2); end
      total++; if (pw2 !== 2'd0) begin bad++; $display("FAIL rst_power: got %0d, required 0", pw2); end
      total++; if ({ovf2, err2, upd2} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b, required 000", {ovf2, err2, upd2}); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle_strobe;
      step(0, 0, 1, 8'd4);
      total++; if (s_err !== 1'b1) begin bad++; $display("FAIL idle_ld_seq_err: got %b, required 1", s_err); end
      total++; if (s_res !== 16'd0) begin bad++; $display("FAIL idle_ld_result: got %0d, required 0", s_res); end
      total++; if (s_upd !== 1'b0) begin bad++; $display("FAIL idle_ld_res_upd: got %b, required 0", s_upd); end
      step(0, 1, 0, 8'd4);
      total++; if (s_pw !== 2'd0) begin bad++; $display("FAIL idle_inc_power: got %0d, required 0", s_pw); end
   endtask

   task automatic test_basic;
      step(1, 0, 0, 8'd5);
      total++; if (s_res !== 16'd1 || s_err !== 1'b0) begin bad++; $display("FAIL basic_init: got result=%0d err=%b, required 1/0", s_res, s_err); end
      step(0, 1, 0, 8'd9);
      total++; if (s_pw !== 2'd1) begin bad++; $display("FAIL basic_power1: got %0d, required 1", s_pw); end
      step(0, 0, 1, 8'd9);
      total++; if (s_res !== 16'd5) begin bad++; $display("FAIL basic_x1: got %0d, required 5", s_res); end
      step(0, 1, 0, 8'd0);
      step(0, 0, 1, 8'd0);
      total++; if (s_res !== 16'd25) begin bad++; $display("FAIL basic_x2: got %0d, required 25", s_res); end
      step(0, 0, 1, 8'd0);
      total++; if (s_res !== 16'd25 || s_pw !== 2'd2) begin bad++; $display("FAIL basic_final: got result=%0d power=%0d, required 25/2", s_res, s_pw); end
      total++; if (s_ovf !== 1'b0 || s_err !== 1'b0) begin bad++; $display("FAIL basic_flags: got ovf=%b err=%b, required 0/0", s_ovf, s_err); end
   endtask

   task automatic test_overrun;
      step(1, 0, 0, 8'd3);
      step(0, 1, 0, 8'd0);
      step(0, 0, 1, 8'd0);
      step(0, 1, 0, 8'd0);
      step(0, 0, 1, 8'd0);
      step(0, 1, 0, 8'd0);
      total++; if (s_err !== 1'b1) begin bad++; $display("FAIL overrun_seq_err: got %b, required 1", s_err); end
      total++; if (s_pw !== 2'd2) begin bad++; $display("FAIL overrun_power: got %0d, required 2", s_pw); end
      total++; if (s_res !== 16'd9) begin bad++; $display("FAIL overrun_result: got %0d, required 9", s_res); end
   endtask

   task automatic test_simultaneous;
      step(1, 1, 0, 8'd6);
      total++; if (s_pw !== 2'd0 || s_res !== 16'd1 || s_err !== 1'b0) begin bad++; $display("FAIL init_inc: got power=%0d result=%0d err=%b, required 0/1/0", s_pw, s_res, s_err); end
      step(0, 1, 0, 8'd0);
      step(0, 0, 1, 8'd0);
      total++; if (s_res !== 16'd6) begin bad++; $display("FAIL init_inc_follow: got %0d, required 6", s_res); end
      step(0, 1, 0, 8'd0);
      step(0, 1, 1, 8'd0);
      total++; if (s_res !== 16'd36 || s_err !== 1'b1 || s_pw !== 2'd2) begin bad++; $display("FAIL ld_inc: got result=%0d err=%b power=%0d, required 36/1/2", s_res, s_err, s_pw); end
      step(0, 1, 0, 8'd0);
      total++; if (s_pw !== 2'd2) begin bad++; $display("FAIL pend_inc_power: got %0d, required 2", s_pw); end
   endtask

   task automatic test_overflow;
      logic [15:0] exp_final;
`ifdef OVF_SAT_EN
      exp_final = 16'hFFFF;
`else
      exp_final = 16'd767;
`endif
      step(0, 0, 0, 8'd0);
      use3 = 1'b1;
      step(1, 0, 0, 8'd255);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 8'd0);
         step(0, 0, 1, 8'd0);
         if (i == 1) begin
            total++; if (s_res !== 16'd65025 || s_ovf !== 1'b0) begin bad++; $display("FAIL ovf_sq: got result=%0d ovf=%b, required 65025/0", s_res, s_ovf); end
         end
      end
      total++; if (s_res !== exp_final) begin bad++; $display("FAIL ovf_result: got %0d, required %0d", s_res, exp_final); end
      total++; if (s_ovf !== 1'b1 || s_pw !== 2'd3) begin bad++; $display("FAIL ovf_flag: got ovf=%b power=%0d, required 1/3", s_ovf, s_pw); end
      step(0, 0, 0, 8'd0);
      use3 = 1'b0;
   endtask

   task automatic test_reset_mid;
      step(1, 0, 0, 8'd4);
      step(0, 1, 0, 8'd0);
      rst_n = 1'b0;
      #1;
      total++; if (s_res !== 16'd0 || s_pw !== 2'd0) begin bad++; $display("FAIL midrst_data: got result=%0d power=%0d, required 0/0", s_res, s_pw); end
      total++; if ({s_ovf, s_err, s_upd} !== 3'b000) begin bad++; $display("FAIL midrst_flags: got %b, required 000", {s_ovf, s_err, s_upd}); end
      m_st = 0; m_k = 0; m_acc = '0; m_x = '0; m_ovf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, 8'd7);
      step(0, 1, 0, 8'd0);
      step(0, 0, 1, 8'd0);
      total++; if (s_res !== 16'd7 || s_pw !== 2'd1) begin bad++; $display("FAIL midrst_recover: got result=%0d power=%0d, required 7/1", s_res, s_pw); end
   endtask

   initial begin
      test_reset();
      test_idle_strobe();
      test_basic();
      test_overrun();
      test_simultaneous();
      test_overflow();
      test_reset_mid();
      step(0, 0, 0, 8'd0);
      step(0, 0, 0, 8'd0);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending updates, required 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
